incubator_climate_ctrl: RTL
===========================

// Module: incubator_climate_ctrl
// PURPOSE
//  Next-generation incubator thermostat FSM: drives heater, cooler and fan from a sampled
//  temperature word. Adds parametrised thresholds, hysteresis, a minimum actuator dwell
//  (relay/compressor protection) and fan run-on. Sits between the sensor interface (valid-qualified
//  samples) and the actuator drivers; all outputs are registered.
// PARAMETERS
//  TEMP_W     8   temperature word width, unsigned
//  LOW_TH     25  heat demand when temp < LOW_TH
//  HIGH_TH    36  cool demand when temp > HIGH_TH; must satisfy LOW_TH < HIGH_TH
//  HYST       2   hysteresis band applied on exit from HEAT/COOL
//  MIN_DWELL  16  min cycles in HEAT or COOL before exit permitted (>=1)
//  FAN_RUNON  8   cycles fan stays on after heater/cooler switch off (>=1)
//  ALARM_LO   15  under-temperature alarm limit (ALARM_EN only)
//  ALARM_HI   45  over-temperature alarm limit (ALARM_EN only)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       reset, synchronous, active-high
//  temp       in   TEMP_W  temperature sample, unsigned
//  temp_valid in   1       temp is valid this cycle; FSM decisions taken only on valid cycles
//  heater     out  1       heater enable
//  cooler     out  1       cooler enable
//  fan        out  1       fan enable
//  state_o    out  2       current state: 0 IDLE, 1 COOL, 2 HEAT, 3 RUNON
//  alarm      out  1       sticky temperature alarm (ALARM_EN only)
//  alarm_clr  in   1       alarm clear request (ALARM_EN only)
// BEHAVIOUR
//  - One clock (clk); rst synchronous active-high. On rst: state IDLE, heater=cooler=fan=0,
//    counters 0, alarm=0. rst mid-operation overrides everything the same edge.
//  - Outputs decoded from next state and registered: decision on edge k visible after edge k.
//    IDLE 0/0/0, COOL cooler=1 fan=1, HEAT heater=1 fan=1, RUNON heater=cooler=0 fan=1.
//  - Compares unsigned; LOW_TH+HYST and HIGH_TH-HYST computed in TEMP_W+1 bits, no wrap.
//  - IDLE: on valid: temp<LOW_TH -> HEAT; temp>HIGH_TH -> COOL; else stay.
//  - HEAT: dwell_cnt cleared on entry, increments each cycle, saturates at MIN_DWELL.
//    Exit only if dwell_cnt==MIN_DWELL and valid and temp>=LOW_TH+HYST -> RUNON.
//  - COOL: same dwell rule; exit when temp<=HIGH_TH-HYST -> RUNON.
//  - Never HEAT<->COOL directly; always via RUNON (heater and cooler never both 1).
//  - RUNON: runon_cnt cleared on entry, counts cycles. On valid: temp<LOW_TH -> HEAT,
//    temp>HIGH_TH -> COOL (demand wins over expiry in the same cycle). Else when
//    runon_cnt==FAN_RUNON-1 -> IDLE (fan high exactly FAN_RUNON cycles if no demand).
//  - temp_valid low: no demand evaluated; counters still advance; RUNON may expire to IDLE.
//  - Illegal state encoding -> IDLE next edge, outputs 0.
// CONFIGURATION
//  - INCUBATOR_ALARM_EN defined: alarm/alarm_clr ports exist. alarm sets on a valid sample
//    with temp<ALARM_LO or temp>ALARM_HI; stays 1 until alarm_clr=1 on a cycle with no set
//    condition (set wins over clear). Alarm does not alter FSM.
//  - Not defined: ports, alarm logic absent; all other behaviour identical.
// TESTING
//  1 rst=1 two cycles, temp=30 valid -> state IDLE, all outputs 0; rst mid-HEAT -> IDLE next edge.
//  2 IDLE, temp=20 valid -> HEAT, heater=fan=1; temp=26 at cycle 5 -> stays HEAT (dwell);
//    temp=27 held -> RUNON at dwell expiry; fan=1 for exactly 8 cycles, then IDLE.
//  3 IDLE, temp=40 -> COOL; after dwell, temp=35 -> stays (35>34); temp=34 -> RUNON.
//  4 COOL dwell expired, temp=10 -> RUNON then HEAT on next valid; heater&cooler never both 1.
//  5 RUNON with temp=40 valid on runon_cnt==7 -> COOL, not IDLE (demand wins).
//  6 INCUBATOR_ALARM_EN: temp=50 -> alarm=1; alarm_clr with temp=50 -> stays 1;
//    temp=30 + alarm_clr -> alarm=0 next edge.

Source files
------------

// File: rtl/incubator_climate_ctrl.sv
// Incubator thermostat FSM with hysteresis, minimum actuator dwell and fan run-on; outputs registered, 1-cycle latency.
// No backpressure: decisions only on temp_valid cycles. Optional sticky alarm enabled by defining INCUBATOR_ALARM_EN.
module incubator_climate_ctrl #(
    parameter int TEMP_W    = 8,
    parameter int LOW_TH    = 25,
    parameter int HIGH_TH   = 36,
    parameter int HYST      = 2,
    parameter int MIN_DWELL = 16,
    parameter int FAN_RUNON = 8
`ifdef INCUBATOR_ALARM_EN
    ,
    parameter int ALARM_LO  = 15,
    parameter int ALARM_HI  = 45
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temp,
    input  logic              temp_valid,
    output logic              heater,
    output logic              cooler,
    output logic              fan,
    output logic [1:0]        state_o
`ifdef INCUBATOR_ALARM_EN
    ,
    output logic              alarm,
    input  logic              alarm_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOL  = 2'd1,
        HEAT  = 2'd2,
        RUNON = 2'd3
    } state_t;

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int RW = (FAN_RUNON > 1) ? $clog2(FAN_RUNON) : 1;
    localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
    localparam logic [RW-1:0] RUNON_LAST = RW'(FAN_RUNON - 1);

    // Thresholds held one bit wider than temp so the hysteresis offsets cannot wrap.
    localparam logic [TEMP_W:0] LOW_T     = (TEMP_W+1)'(LOW_TH);
    localparam logic [TEMP_W:0] HIGH_T    = (TEMP_W+1)'(HIGH_TH);
    localparam logic [TEMP_W:0] HEAT_EXIT = (TEMP_W+1)'(LOW_TH + HYST);
    localparam logic [TEMP_W:0] COOL_EXIT = (HIGH_TH > HYST) ? (TEMP_W+1)'(HIGH_TH - HYST) : '0;

    state_t          state, state_n;
    logic [DW-1:0]   dwell_cnt, dwell_n;
    logic [RW-1:0]   runon_cnt, runon_n;
    logic            heater_n, cooler_n, fan_n;
    logic [TEMP_W:0] temp_x;
    logic            too_cold, too_hot;

    assign temp_x   = {1'b0, temp};
    assign too_cold = temp_valid && (temp_x < LOW_T);
    assign too_hot  = temp_valid && (temp_x > HIGH_T);
    assign state_o  = state;

    always_comb begin
        state_n  = state;
        dwell_n  = dwell_cnt;
        runon_n  = runon_cnt;
        heater_n = 1'b0;
        cooler_n = 1'b0;
        fan_n    = 1'b0;

        case (state)
            IDLE: begin
                if (too_cold)     state_n = HEAT;
                else if (too_hot) state_n = COOL;
            end
            HEAT: begin
                if (dwell_cnt == DWELL_MAX && temp_valid && temp_x >= HEAT_EXIT)
                    state_n = RUNON;
            end
            COOL: begin
                if (dwell_cnt == DWELL_MAX && temp_valid && temp_x <= COOL_EXIT)
                    state_n = RUNON;
            end
            RUNON: begin
                // Fresh demand takes priority over run-on expiry.
                if (too_cold)                     state_n = HEAT;
                else if (too_hot)                 state_n = COOL;
                else if (runon_cnt == RUNON_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state) begin
            dwell_n = '0;
            runon_n = '0;
        end else if ((state == HEAT || state == COOL) && dwell_cnt != DWELL_MAX) begin
            dwell_n = dwell_cnt + 1'b1;
        end else if (state == RUNON) begin
            runon_n = runon_cnt + 1'b1;
        end

        case (state_n)
            COOL:    begin cooler_n = 1'b1; fan_n = 1'b1; end
            HEAT:    begin heater_n = 1'b1; fan_n = 1'b1; end
            RUNON:   fan_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            runon_cnt <= '0;
            heater    <= 1'b0;
            cooler    <= 1'b0;
            fan       <= 1'b0;
        end else begin
            state     <= state_n;
            dwell_cnt <= dwell_n;
            runon_cnt <= runon_n;
            heater    <= heater_n;
            cooler    <= cooler_n;
            fan       <= fan_n;
        end
    end

`ifdef INCUBATOR_ALARM_EN
    localparam logic [TEMP_W:0] ALARM_LO_T = (TEMP_W+1)'(ALARM_LO);
    localparam logic [TEMP_W:0] ALARM_HI_T = (TEMP_W+1)'(ALARM_HI);

    logic alarm_set;
    assign alarm_set = temp_valid && (temp_x < ALARM_LO_T || temp_x > ALARM_HI_T);

    // Set wins over clear so a persisting fault cannot be acknowledged away.
    always_ff @(posedge clk) begin
        if (rst)            alarm <= 1'b0;
        else if (alarm_set) alarm <= 1'b1;
        else if (alarm_clr) alarm <= 1'b0;
    end
`endif

endmodule
